// File: rtl/weighted_round_robin_packet_arbiter_pkg.sv
// rtl/weighted_round_robin_packet_arbiter_pkg.sv - shared types for the weighted round-robin packet arbiter
package weighted_round_robin_packet_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/weighted_round_robin_packet_arbiter_round_robin_select.sv
// rtl/weighted_round_robin_packet_arbiter_round_robin_select.sv - first set request after pointer, with wrap
module weighted_round_robin_packet_arbiter_round_robin_select #(
    parameter int SIZE      = 4,
    parameter int SIZE_LOG2 = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]      requests,
    input  logic [SIZE_LOG2-1:0] pointer,
    output logic [SIZE-1:0]      onehot,
    output logic [SIZE_LOG2-1:0] index,
    output logic                 found
);

    logic [2*SIZE-1:0] masked;

    // Lower copy keeps only bits above the pointer; upper copy supplies the wrap-around.
    always_comb begin
        masked = {requests, requests};
        for (int i = 0; i < SIZE; i++) begin
            if (i <= int'(pointer)) begin
                masked[i] = 1'b0;
            end
        end
        index = '0;
        found = 1'b0;
        for (int i = 2*SIZE-1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                if (i >= SIZE) begin
                    index = SIZE_LOG2'(i - SIZE);
                end else begin
                    index = SIZE_LOG2'(i);
                end
            end
        end
        onehot = found ? (SIZE'(1) << index) : '0;
    end

endmodule

// File: rtl/weighted_round_robin_packet_arbiter.sv
// rtl/weighted_round_robin_packet_arbiter.sv - packet-granular weighted round-robin arbiter for a shared stream
module weighted_round_robin_packet_arbiter
    import weighted_round_robin_packet_arbiter_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int SIZE_LOG2   = $clog2(SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests_valid,
    input  logic [SIZE-1:0]              requests_last,
    output logic [SIZE-1:0]              requests_ready,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    output logic                         output_valid,
    output logic                         output_last,
    input  logic                         output_ready,
    output logic [SIZE-1:0]              grant,
    output logic [SIZE_LOG2-1:0]         grant_index
);

    arb_state_t              state_q, state_d;
    logic [SIZE-1:0]         grant_q, grant_d;
    logic [SIZE_LOG2-1:0]    grant_index_q, grant_index_d;
    logic [SIZE_LOG2-1:0]    pointer_q, pointer_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic                    in_packet_q, in_packet_d;

    logic [SIZE-1:0]         sel_onehot;
    logic [SIZE_LOG2-1:0]    sel_index;
    logic                    sel_found;
    logic [WEIGHT_WIDTH-1:0] sel_weight;
    logic                    transfer;
    logic                    release_turn;

    weighted_round_robin_packet_arbiter_round_robin_select #(
        .SIZE      (SIZE),
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_select (
        .requests (requests_valid),
        .pointer  (pointer_q),
        .onehot   (sel_onehot),
        .index    (sel_index),
        .found    (sel_found)
    );

    assign sel_weight  = weights[int'(sel_index)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign grant       = grant_q;
    assign grant_index = grant_index_q;
    assign transfer    = output_valid & output_ready;

    always_comb begin
        output_valid   = 1'b0;
        output_last    = 1'b0;
        requests_ready = '0;
        if (state_q == GRANTED) begin
            output_valid                  = requests_valid[grant_index_q];
            output_last                   = requests_last[grant_index_q];
            requests_ready[grant_index_q] = output_ready;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        pointer_d     = pointer_q;
        credit_d      = credit_q;
        in_packet_d   = in_packet_q;
        release_turn  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d       = GRANTED;
                    grant_d       = sel_onehot;
                    grant_index_d = sel_index;
                    pointer_d     = sel_index;
                    credit_d      = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
                    in_packet_d   = 1'b0;
                end
            end
            GRANTED: begin
                if (transfer && output_last) begin
                    in_packet_d = 1'b0;
                    credit_d    = credit_q - WEIGHT_WIDTH'(1);
                    if (credit_q == WEIGHT_WIDTH'(1)) begin
                        release_turn = 1'b1;
                    end
                end else if (transfer) begin
                    in_packet_d = 1'b1;
                end else if (!in_packet_q && !requests_valid[grant_index_q]) begin
                    // Dropping valid between packets forfeits the rest of the turn.
                    release_turn = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_turn) begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_index_d = '0;
            credit_d      = '0;
            in_packet_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_index_q <= '0;
            pointer_q     <= SIZE_LOG2'(SIZE-1);
            credit_q      <= '0;
            in_packet_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            pointer_q     <= pointer_d;
            credit_q      <= credit_d;
            in_packet_q   <= in_packet_d;
        end
    end

endmodule

// File: doc/weighted_round_robin_packet_arbiter.md
Name: weighted_round_robin_packet_arbiter

Overview:
Shares one downstream channel (valid/ready/last) between SIZE packet-based requesters. Grants with round-robin fairness and holds the grant for whole packets. Each requester may send up to a configurable number of consecutive packets (weight) before priority rotates. Drives the select of the shared data multiplexer through grant and grant_index, and routes the valid/ready handshake between the granted requester and the output.

Parameters:
SIZE, 4, number of requesters (>=2)
WEIGHT_WIDTH, 4, width of each per-requester weight field
SIZE_LOG2 (localparam), CLOG2(SIZE), width of grant_index

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-high reset
requests_valid  input  SIZE  per-requester beat valid
requests_last  input  SIZE  per-requester last beat of packet
requests_ready  output  SIZE  per-requester beat accepted (only granted bit may be 1)
weights  input  SIZE*WEIGHT_WIDTH  packets per turn; field i = bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; value 0 treated as 1
output_valid  output  1  shared channel valid
output_last  output  1  shared channel last
output_ready  input  1  shared channel ready
grant  output  SIZE  registered one-hot grant (mux select), all-zero when idle
grant_index  output  SIZE_LOG2  binary index of granted requester, 0 when idle

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, grant=0, grant_index=0, pointer=SIZE-1 (requester 0 has top priority first), credit=0, in_packet=0. All outputs are therefore 0 after reset. Reset asserted mid-packet aborts the packet, and grant is 0 from the next edge.
- State IDLE: outputs idle. If any requests_valid bit is set, select the first set bit searching from pointer+1 upward, wrapping modulo SIZE. Next cycle: state=GRANTED, grant=onehot(sel), grant_index=sel, pointer=sel, credit=max(weights[sel],1), in_packet=0. Request-to-grant latency is 1 cycle.
- State GRANTED (g = grant_index):
  - output_valid = requests_valid[g], output_last = requests_last[g], requests_ready[g] = output_ready, other ready bits = 0. These are combinational pass-through.
  - A transfer is output_valid & output_ready.
  - Transfer with last=0 sets in_packet=1.
  - Transfer with last=1 clears in_packet and decrements credit. If credit was 1, the block releases: state=IDLE and grant=0 next cycle.
  - At a packet boundary (in_packet=0) with requests_valid[g]=0, the block releases: state=IDLE next cycle, and unused credit is discarded.
  - While in_packet=1, the grant is held regardless of requests_valid[g] (bubbles allowed) or output_ready.
- Every release costs exactly one IDLE cycle (no back-to-back regrant). The pointer stays at the last granted index, so the next search starts at g+1.
- The weights input is sampled only at grant time. Changes during a turn take effect on the next grant.
- Credit counter width is WEIGHT_WIDTH. No wrap is possible because it decrements from a value of at least 1 and release occurs at 1.
- A requester that drops valid outside a packet loses its turn. No starvation: any valid requester is granted within SIZE-1 turns.
- requests_last is ignored when requests_valid is 0.

Decomposition:
- Shared package: state encoding (IDLE, GRANTED) only. The width helpers come from common.vh (CLOG2).
- One combinational sub-module is natural: round_robin_select (inputs requests and pointer; outputs one-hot and index of the first set bit after pointer, with wrap). It uses a double-width mask/priority-encode implementation.
- The FSM, credit counter and handshake routing stay in the top module.

Test Plan:
1. Reset, then requests_valid=0b0101 constant, single-beat packets (last=1), output_ready=1, weights all 1 -> grant=0001 one cycle later, IDLE cycle, then 0100, then 0001; grant_index toggles 0/2.
2. All four valid with continuous single-beat packets, weights all 1 -> grant order 0,1,2,3,0 with exactly one grant=0 cycle between turns; 4 transfers per 8 cycles.
3. weights[1]=3, others 1, only requester 1 and 2 valid continuously -> requester 1 gets 3 packets, then requester 2 gets 1, then requester 1 gets 3 again.
4. Requester 2 sends a 4-beat packet; its valid is low on beat 3 for 2 cycles, and output_ready toggles 1,0,1 -> grant stays 0100 throughout, requests_ready[2] mirrors output_ready, release only after the last transfer.
5. weights[0]=0, requesters 0 and 1 valid -> requester 0 gets exactly 1 packet before requester 1.
6. Reset pulse during beat 2 of a requester 3 packet -> grant=0 and output_valid=0 on the next cycle; a later request from 0 and 3 grants 0 first (pointer back at SIZE-1).
